// File: rtl/f1_reaction_controller_if.sv
// Signal bundle between the F1 reaction controller and its surroundings
// (debounced buttons, light sequencer, display/score logic).
interface f1_reaction_controller_if #(
  parameter int unsigned CNT_W = 14
);
  logic             tick;
  logic             start_btn;
  logic             react_btn;
  logic             time_out;
  logic             trigger;
  logic             busy;
  logic             result_valid;
  logic [CNT_W-1:0] react_ms;
  logic [CNT_W-1:0] best_ms;
  logic             new_best;
  logic             jump_start;
  logic             no_react;

  // Drives the inputs and observes the results (buttons, sequencer, display side)
  modport master (
    output tick, start_btn, react_btn, time_out,
    input  trigger, busy, result_valid, react_ms, best_ms, new_best, jump_start, no_react
  );

  // The reaction controller itself
  modport slave (
    input  tick, start_btn, react_btn, time_out,
    output trigger, busy, result_valid, react_ms, best_ms, new_best, jump_start, no_react
  );
endinterface

// File: rtl/f1_reaction_controller.sv
// Race-level controller: launches the light sequence, times the reaction from
// lights-out to the react button press, flags jump starts/timeouts, keeps best time.
module f1_reaction_controller #(
  parameter int unsigned CNT_W  = 14,
  parameter int unsigned MAX_MS = 9999,
  parameter int unsigned MIN_MS = 100
) (
  input  logic                    sysclk,
  input  logic                    rst,
  f1_reaction_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_MS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEQ    = 2'd1,
    TIMING = 2'd2,
    RESULT = 2'd3
  } state_e;

  state_e           state_q;
  logic             start_btn_q;
  logic             react_btn_q;
  logic             trigger_q;
  logic             busy_q;
  logic             result_valid_q;
  logic [CNT_W-1:0] react_ms_q;
  logic [CNT_W-1:0] best_ms_q;
  logic [CNT_W-1:0] count_q;
  logic             new_best_q;
  logic             jump_start_q;
  logic             no_react_q;

  logic start_rise_c;
  logic react_rise_c;

  // History regs reset to 1 so a button held through reset never looks like a press
  assign start_rise_c = bus.start_btn & ~start_btn_q;
  assign react_rise_c = bus.react_btn & ~react_btn_q;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q        <= IDLE;
      start_btn_q    <= 1'b1;
      react_btn_q    <= 1'b1;
      trigger_q      <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      react_ms_q     <= '0;
      best_ms_q      <= MAX_C;
      count_q        <= '0;
      new_best_q     <= 1'b0;
      jump_start_q   <= 1'b0;
      no_react_q     <= 1'b0;
    end else begin
      start_btn_q <= bus.start_btn;
      react_btn_q <= bus.react_btn;
      trigger_q   <= 1'b0;

      unique case (state_q)
        IDLE, RESULT: begin
          if (start_rise_c) begin
            state_q        <= SEQ;
            trigger_q      <= 1'b1;
            busy_q         <= 1'b1;
            result_valid_q <= 1'b0;
            react_ms_q     <= '0;
            new_best_q     <= 1'b0;
            jump_start_q   <= 1'b0;
            no_react_q     <= 1'b0;
            count_q        <= '0;
          end
        end

        SEQ: begin
          // A press before lights-out beats a simultaneous lights-out
          if (react_rise_c) begin
            state_q        <= RESULT;
            busy_q         <= 1'b0;
            jump_start_q   <= 1'b1;
            react_ms_q     <= '0;
            result_valid_q <= 1'b1;
          end else if (bus.time_out) begin
            state_q <= TIMING;
            count_q <= '0;
          end
        end

        TIMING: begin
          if (react_rise_c && (count_q < MIN_C)) begin
            state_q        <= RESULT;
            busy_q         <= 1'b0;
            jump_start_q   <= 1'b1;
            react_ms_q     <= count_q;
            result_valid_q <= 1'b1;
          end else if (react_rise_c) begin
            state_q        <= RESULT;
            busy_q         <= 1'b0;
            react_ms_q     <= count_q;
            result_valid_q <= 1'b1;
            if (count_q < best_ms_q) begin
              best_ms_q  <= count_q;
              new_best_q <= 1'b1;
            end
          end else if (count_q == MAX_C) begin
            state_q        <= RESULT;
            busy_q         <= 1'b0;
            no_react_q     <= 1'b1;
            react_ms_q     <= MAX_C;
            result_valid_q <= 1'b1;
          end else if (bus.tick && (count_q < MAX_C)) begin
            count_q <= count_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trigger      = trigger_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.react_ms     = react_ms_q;
  assign bus.best_ms      = best_ms_q;
  assign bus.new_best     = new_best_q;
  assign bus.jump_start   = jump_start_q;
  assign bus.no_react     = no_react_q;

endmodule
